// File: rtl/common_pkg.sv
// Shared types and helpers for the set-bit enumerator.
// Holds the FSM state encoding and the index-width helper.
package common_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_iter_state_t;

    // Index width for a w-bit mask; never narrower than one bit.
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/pri_enc.sv
// Combinational priority encoder, lowest set bit wins.
// Ports: x_i (mask) -> any_o (mask non-zero), idx_o (lowest set bit index).
module pri_enc
    import common_pkg::*;
#(
    parameter  int W     = 32,
    localparam int IDX_W = idx_w(W)
) (
    input  logic [W-1:0]     x_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last to write.
        for (int i = W - 1; i >= 0; i--) begin
            if (x_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |x_i;

endmodule

// File: rtl/enc_iter.sv
// Set-bit enumerator: streams the index of every set bit of a mask, LSB first.
// Ports: clk, rst (sync, active-high); in_vld_i/in_x_i/in_rdy_o mask input;
//   out_vld_o/out_y_o/out_last_o/out_rdy_i index output; busy_o while emitting.
// Option: define ENC_ITER_ONEHOT_EN to add out_oh_o, the isolated lowest bit.
module enc_iter
    import common_pkg::*;
#(
    parameter  int W     = 32,
    localparam int IDX_W = idx_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    input  logic [W-1:0]     in_x_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    output logic [IDX_W-1:0] out_y_o,
    output logic             out_last_o,
    input  logic             out_rdy_i,
    output logic             busy_o
`ifdef ENC_ITER_ONEHOT_EN
    ,
    output logic [W-1:0]     out_oh_o
`endif
);

    enc_iter_state_t state_q;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_pop;
    logic            r_any;
    logic [IDX_W-1:0] r_idx;
    logic            emit;
    logic            last;
    logic            accept;
    logic            pop;

    pri_enc #(.W(W)) u_pri_enc (
        .x_i   (r_q),
        .any_o (r_any),
        .idx_o (r_idx)
    );

    // Residual with its lowest set bit cleared.
    assign r_pop = r_q & (r_q - W'(1));

    // r is never zero in EMIT; r_any only guards against that invariant.
    assign emit = (state_q == EMIT) && r_any;
    assign last = (r_pop == '0);

    assign pop    = emit && out_rdy_i;
    // A new mask may enter in the same cycle the final index pops.
    assign in_rdy_o = (state_q == IDLE) || (pop && last);
    assign accept = in_vld_i && in_rdy_o;

    assign out_vld_o  = emit;
    assign out_y_o    = emit ? r_idx : '0;
    assign out_last_o = emit && last;
    assign busy_o     = (state_q == EMIT);

`ifdef ENC_ITER_ONEHOT_EN
    assign out_oh_o = emit ? (r_q & (~r_q + W'(1))) : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
        end else if (accept) begin
            // A zero mask is consumed without emitting anything.
            r_q     <= in_x_i;
            state_q <= (in_x_i != '0) ? EMIT : IDLE;
        end else if (pop) begin
            r_q <= r_pop;
            if (last) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_enc_iter.sv
// Directed testbench for enc_iter at W=8.
// Hand-computed index sequences for drain, stall, back-to-back and reset cases.
module tb_enc_iter;

    localparam int W     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic             in_vld_i;
    logic [W-1:0]     in_x_i;
    logic             in_rdy_o;
    logic             out_vld_o;
    logic [IDX_W-1:0] out_y_o;
    logic             out_last_o;
    logic             out_rdy_i;
    logic             busy_o;
`ifdef ENC_ITER_ONEHOT_EN
    logic [W-1:0]     out_oh_o;
`endif

    int n_vec;
    int n_err;

    enc_iter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld_i   (in_vld_i),
        .in_x_i     (in_x_i),
        .in_rdy_o   (in_rdy_o),
        .out_vld_o  (out_vld_o),
        .out_y_o    (out_y_o),
        .out_last_o (out_last_o),
        .out_rdy_i  (out_rdy_i),
        .busy_o     (busy_o)
`ifdef ENC_ITER_ONEHOT_EN
        ,
        .out_oh_o   (out_oh_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and checks happen 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".vld"}, 32'(out_vld_o), 32'd0);
        check({tag, ".busy"}, 32'(busy_o), 32'd0);
        check({tag, ".rdy"}, 32'(in_rdy_o), 32'd1);
        check({tag, ".y"}, 32'(out_y_o), 32'd0);
        check({tag, ".last"}, 32'(out_last_o), 32'd0);
`ifdef ENC_ITER_ONEHOT_EN
        check({tag, ".oh"}, 32'(out_oh_o), 32'd0);
`endif
    endtask

    task automatic expect_idx(input string tag, input int y, input bit lst);
        logic [31:0] one;
        one = 32'd1;
        check({tag, ".vld"}, 32'(out_vld_o), 32'd1);
        check({tag, ".busy"}, 32'(busy_o), 32'd1);
        check({tag, ".y"}, 32'(out_y_o), 32'(y));
        check({tag, ".last"}, 32'(out_last_o), 32'(lst));
`ifdef ENC_ITER_ONEHOT_EN
        check({tag, ".oh"}, 32'(out_oh_o), one << y);
`endif
    endtask

    task automatic accept(input logic [W-1:0] m);
        in_vld_i = 1'b1;
        in_x_i   = m;
        check("acc.rdy", 32'(in_rdy_o), 32'd1);
        step();
        in_vld_i = 1'b0;
        in_x_i   = '0;
    endtask

    // Drain with out_rdy_i held high, one index per cycle.
    task automatic drain(input string tag, input int q[$]);
        out_rdy_i = 1'b1;
        foreach (q[i]) begin
            expect_idx($sformatf("%s[%0d]", tag, i), q[i], i == q.size() - 1);
            step();
        end
        expect_idle({tag, ".end"});
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_vld_i  = 1'b0;
        in_x_i    = '0;
        out_rdy_i = 1'b0;

        step();
        step();
        rst = 1'b0;
        expect_idle("reset");

        // Basic drain
        out_rdy_i = 1'b1;
        accept(8'b1010_0101);
        drain("basic", '{0, 2, 5, 7});

        // Backpressure: first index held for 4 cycles
        out_rdy_i = 1'b0;
        accept(8'b1010_0101);
        for (int i = 0; i < 3; i++) begin
            expect_idx($sformatf("stall%0d", i), 0, 1'b0);
            check("stall.rdy", 32'(in_rdy_o), 32'd0);
            step();
        end
        out_rdy_i = 1'b1;
        expect_idx("stall3", 0, 1'b0);
        step();
        drain("bp", '{2, 5, 7});

        // Back-to-back: 0x03 then 0x80, no bubble
        out_rdy_i = 1'b1;
        accept(8'b0000_0011);
        in_vld_i = 1'b1;
        in_x_i   = 8'b1000_0000;
        expect_idx("b2b0", 0, 1'b0);
        check("b2b0.rdy", 32'(in_rdy_o), 32'd0);
        step();
        expect_idx("b2b1", 1, 1'b1);
        check("b2b1.rdy", 32'(in_rdy_o), 32'd1);
        step();
        in_vld_i = 1'b0;
        in_x_i   = '0;
        drain("b2b2", '{7});

        // Zero mask consumed silently
        accept(8'h00);
        expect_idle("zero0");
        step();
        expect_idle("zero1");

        // Full mask
        accept(8'hFF);
        drain("full", '{0, 1, 2, 3, 4, 5, 6, 7});

        // Reset mid-EMIT
        accept(8'hF0);
        expect_idx("rm0", 4, 1'b0);
        step();
        expect_idx("rm1", 5, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_idle("rm.rst");
        for (int i = 0; i < 3; i++) begin
            step();
            expect_idle($sformatf("rm.post%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
